// File: rtl/abs_sub_arbiter.sv
// Round-robin arbiter in front of one shared signed |A-B| unit.
// One operation is three cycles long: capture (IDLE), compute (BUSY), report (DONE).
module abs_sub_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      i_abs_sub_arbiter_clk,
    input  logic                      i_abs_sub_arbiter_rst,
    input  logic [NUM_REQ-1:0]        i_abs_sub_arbiter_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_abs_sub_arbiter_A,
    input  logic [NUM_REQ*DATA_W-1:0] i_abs_sub_arbiter_B,
    output logic [NUM_REQ-1:0]        o_abs_sub_arbiter_ack,
    output logic                      o_abs_sub_arbiter_valid,
    output logic [ID_W-1:0]           o_abs_sub_arbiter_id,
    output logic [DATA_W-1:0]         o_abs_sub_arbiter_value,
    output logic                      o_abs_sub_arbiter_busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   idx_q, idx_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    int                scan_j;

    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0]      abs_val;

    // First set request at or after ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_j      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_j = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && i_abs_sub_arbiter_req[scan_j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_j);
            end
        end
    end

    // One extra bit makes the signed difference exact; its magnitude always fits DATA_W.
    always_comb begin
        diff    = {a_q[DATA_W-1], a_q} - {b_q[DATA_W-1], b_q};
        abs_val = diff[DATA_W] ? DATA_W'(-diff) : DATA_W'(diff);
    end

    always_ff @(posedge i_abs_sub_arbiter_clk) begin
        if (i_abs_sub_arbiter_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = BUSY;
            BUSY:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        value_d = value_q;
        ack_d   = '0;
        valid_d = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    idx_d = grant_idx;
                    a_d   = i_abs_sub_arbiter_A[grant_idx*DATA_W +: DATA_W];
                    b_d   = i_abs_sub_arbiter_B[grant_idx*DATA_W +: DATA_W];
                end
            end
            BUSY: begin
                value_d       = abs_val;
                id_d          = idx_q;
                valid_d       = 1'b1;
                ack_d[idx_q]  = 1'b1;
            end
            DONE: begin
                ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_abs_sub_arbiter_clk) begin
        if (i_abs_sub_arbiter_rst) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            value_q <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            value_q <= value_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_abs_sub_arbiter_ack   = ack_q;
    assign o_abs_sub_arbiter_valid = valid_q;
    assign o_abs_sub_arbiter_id    = id_q;
    assign o_abs_sub_arbiter_value = value_q;
    assign o_abs_sub_arbiter_busy  = busy_q;

endmodule

// File: tb/tb_abs_sub_arbiter.sv
// Directed bench for abs_sub_arbiter: vector table plus multi-cycle corner sequences.
module tb_abs_sub_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] A, B;
    logic [NUM_REQ-1:0]        ack;
    logic                      valid;
    logic [ID_W-1:0]           id;
    logic [DATA_W-1:0]         value;
    logic                      busy;

    int checks = 0;
    int errors = 0;

    abs_sub_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .i_abs_sub_arbiter_clk  (clk),
        .i_abs_sub_arbiter_rst  (rst),
        .i_abs_sub_arbiter_req  (req),
        .i_abs_sub_arbiter_A    (A),
        .i_abs_sub_arbiter_B    (B),
        .o_abs_sub_arbiter_ack  (ack),
        .o_abs_sub_arbiter_valid(valid),
        .o_abs_sub_arbiter_id   (id),
        .o_abs_sub_arbiter_value(value),
        .o_abs_sub_arbiter_busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        int slot;
        int a;
        int b;
        int exp_id;
        int exp_val;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ops(input int slot, input int a, input int b);
        logic [DATA_W-1:0] av, bv;
        av = a[DATA_W-1:0];
        bv = b[DATA_W-1:0];
        A[slot*DATA_W +: DATA_W] = av;
        B[slot*DATA_W +: DATA_W] = bv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a result, checks it, and drops the served request bit.
    task automatic serve(input string nm, input int exp_id, input int exp_val, output int lat);
        logic got;
        logic [NUM_REQ-1:0] oh;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 12) begin
            step();
            lat++;
            got = valid;
        end
        chk({nm, "_valid_seen"}, int'(got), 1);
        if (got) begin
            oh = '0;
            oh[exp_id] = 1'b1;
            chk({nm, "_id"}, int'(id), exp_id);
            chk({nm, "_value"}, int'(value), exp_val);
            chk({nm, "_ack"}, int'(ack), int'(oh));
            req[id] = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int nv;
        int last;
        int exp_seq[5];
        logic [NUM_REQ-1:0] oh;

        rst = 1'b1;
        req = '0;
        A   = '0;
        B   = '0;
        step();
        step();
        chk("rst_ack", int'(ack), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_id", int'(id), 0);
        chk("rst_value", int'(value), 0);
        rst = 1'b0;
        step();

        vecs[0] = '{4'b0001, 0,  5, -3, 0,  8};
        vecs[1] = '{4'b0001, 0, -8,  7, 0, 15};
        vecs[2] = '{4'b0001, 0,  7, -8, 0, 15};
        vecs[3] = '{4'b0001, 0, -4, -4, 0,  0};
        vecs[4] = '{4'b0001, 0, -1, -8, 0,  7};
        vecs[5] = '{4'b0010, 1,  0, -8, 1,  8};
        vecs[6] = '{4'b0100, 2,  3,  6, 2,  3};
        vecs[7] = '{4'b1000, 3, -8, -8, 3,  0};

        foreach (vecs[v]) begin
            oh = '0;
            oh[vecs[v].exp_id] = 1'b1;
            chk($sformatf("v%0d_idle_busy", v), int'(busy), 0);
            set_ops(vecs[v].slot, vecs[v].a, vecs[v].b);
            req = vecs[v].req;
            step();
            chk($sformatf("v%0d_c1_busy", v), int'(busy), 1);
            chk($sformatf("v%0d_c1_valid", v), int'(valid), 0);
            chk($sformatf("v%0d_c1_ack", v), int'(ack), 0);
            step();
            chk($sformatf("v%0d_c2_valid", v), int'(valid), 1);
            chk($sformatf("v%0d_c2_ack", v), int'(ack), int'(oh));
            chk($sformatf("v%0d_c2_id", v), int'(id), vecs[v].exp_id);
            chk($sformatf("v%0d_c2_value", v), int'(value), vecs[v].exp_val);
            chk($sformatf("v%0d_c2_busy", v), int'(busy), 1);
            req = '0;
            step();
            chk($sformatf("v%0d_c3_valid", v), int'(valid), 0);
            chk($sformatf("v%0d_c3_ack", v), int'(ack), 0);
            chk($sformatf("v%0d_c3_busy", v), int'(busy), 0);
            chk($sformatf("v%0d_c3_hold", v), int'(value), vecs[v].exp_val);
        end

        // All four requesting continuously from ptr=0: rotation 0,1,2,3,0 every 3 cycles.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, i, -i);
        exp_seq = '{0, 1, 2, 3, 0};
        nv = 0;
        last = 0;
        req = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (valid) begin
                if (nv < 5) begin
                    chk($sformatf("rr%0d_id", nv), int'(id), exp_seq[nv]);
                    chk($sformatf("rr%0d_value", nv), int'(value), 2 * exp_seq[nv]);
                    if (nv == 0) chk("rr_first_lat", c, 2);
                    else chk($sformatf("rr%0d_gap", nv), c - last, 3);
                end
                last = c;
                nv++;
            end
        end
        chk("rr_count", nv, 5);
        req = '0;
        step();
        step();

        // ptr=2 after serving id1, so 1001 goes to id3 before id0.
        do_reset();
        set_ops(1, 2, -1);
        req = 4'b0010;
        serve("p2_id1", 1, 3, lat);
        set_ops(3, -8, 0);
        set_ops(0, 1, 1);
        req = 4'b1001;
        serve("p2_first", 3, 8, lat);
        serve("p2_second", 0, 0, lat);
        req = '0;
        step();
        step();

        // Reset during BUSY aborts and returns ptr to 0.
        do_reset();
        set_ops(1, 7, -8);
        req = 4'b0010;
        serve("ab_pre", 1, 15, lat);
        step();
        set_ops(2, 1, 0);
        req = 4'b0110;
        step();
        chk("ab_busy_before", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("ab_valid", int'(valid), 0);
        chk("ab_ack", int'(ack), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_id", int'(id), 0);
        chk("ab_value", int'(value), 0);
        rst = 1'b0;
        serve("ab_post", 1, 15, lat);
        chk("ab_post_lat", lat, 2);
        req = '0;
        step();
        step();

        // Operands changed right after capture must not affect the result.
        set_ops(0, 5, -3);
        req = 4'b0001;
        step();
        set_ops(0, 0, 0);
        serve("cap", 0, 8, lat);
        chk("cap_lat", lat, 1);
        req = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
